id_ex_pipeline_reg: RTL
=======================

Name: id_ex_pipeline_reg

Overview:
- Decode-to-execute pipeline register, directly downstream of the decode control unit.
- Captures the decode control word (alu_src, branch_src, mem_write, alu_mux_src, wb_src, reg_write), register operands, extended immediate, PC values and register indices each cycle.
- Presents them to the execute stage with one cycle of latency.
- Implements hazard-unit stall, flush (branch/jump redirect) and load-use bubble insertion.
- Tracks a valid bit so squashed slots never write state.

Parameters:
- DATA_WIDTH, 32, width of operands, immediate and PC fields
- REG_ADDR_WIDTH, 5, width of rs1/rs2/rd indices

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- stall_e  input  1  hold current contents (execute stalled)
- flush_e  input  1  squash: load a NOP next edge
- bubble_e  input  1  insert NOP (load-use hazard); decode holds upstream
- valid_d  input  1  decode slot holds a real instruction
- alu_src_d  input  5  ALU operation select
- branch_src_d  input  3  branch/jump type; 0 = no branch
- mem_write_d  input  1  store enable
- alu_mux_src_d  input  2  ALU operand-B select
- wb_src_d  input  2  writeback select
- reg_write_d  input  1  register-file write enable
- funct3_d  input  3  load/store size and branch condition bits
- rd1_d, rd2_d  input  DATA_WIDTH  register operands
- imm_ext_d  input  DATA_WIDTH  extended immediate
- pc_d, pc_plus4_d  input  DATA_WIDTH  PC and PC+4
- rs1_d, rs2_d, rd_d  input  REG_ADDR_WIDTH  register indices
- valid_e  output  1  execute slot holds a real instruction
- alu_src_e … rd_e  output  same widths as the *_d inputs  registered copies

Behaviour:
- All outputs are flops; single-cycle latency; no combinational path from input to output.
- Reset (rst_n=0, asynchronous) drives every output to 0. This is a NOP: valid_e=0, reg_write_e=0, mem_write_e=0, branch_src_e=0.
- Per rising edge, priority order: flush_e > bubble_e > stall_e > load.
  - flush_e=1:
    - valid_e, reg_write_e, mem_write_e and branch_src_e go to 0.
    - alu_src_e, alu_mux_src_e, wb_src_e, funct3_e go to 0.
    - Datapath fields (rd1..rd, pc) also go to 0.
  - bubble_e=1 (flush_e=0): identical NOP load as flush.
  - stall_e=1 (flush_e=0, bubble_e=0): all outputs hold their value, including valid_e.
  - Otherwise (load): all *_e outputs take the *_d values and valid_e=valid_d.
- Load with valid_d=0: control fields reg_write_e, mem_write_e and branch_src_e are forced to 0. Datapath fields are still captured.
- Simultaneous stall_e and flush_e: flush wins; the slot is squashed.
- Simultaneous stall_e and bubble_e: bubble wins.
- Reset mid-operation clears state immediately, regardless of stall.
- Invariant: valid_e=0 implies reg_write_e=0, mem_write_e=0 and branch_src_e=0.
- No internal arithmetic; widths pass through unchanged.

Optional Feature:
- Macro: ID_EX_STATS_EN.
- Defined:
  - Adds outputs bubble_count_e [31:0] and flush_count_e [31:0].
  - Both are reset to 0 by rst_n.
  - bubble_count_e increments on each edge where bubble_e=1 and flush_e=0.
  - flush_count_e increments on each edge where flush_e=1.
  - Both wrap modulo 2^32; stall_e does not affect them.
- Undefined: the ports and counters do not exist; the pipeline register behaves identically otherwise.

Test Plan:
- Reset then load: assert rst_n=0 mid-cycle → all outputs 0 immediately. Release, then drive valid_d=1, reg_write_d=1, alu_src_d=5'h02, rd1_d=32'h0000_0010, rd_d=5'd7 → next edge: valid_e=1, reg_write_e=1, alu_src_e=5'h02, rd1_e=32'h10, rd_e=7.
- Stall hold: load pc_d=32'h0000_0100, then stall_e=1 for 3 cycles while pc_d=32'h104, 32'h108 → pc_e stays 32'h100 throughout. Release → pc_e=32'h108 next edge.
- Flush priority: stall_e=1 and flush_e=1 with valid_e=1, mem_write_e=1 → next edge: valid_e=0, mem_write_e=0, branch_src_e=0, all fields 0.
- Bubble: bubble_e=1 with valid_d=1, reg_write_d=1, branch_src_d=3'd2 → valid_e=0, reg_write_e=0, branch_src_e=0. Next cycle with bubble_e=0 → decoded values appear.
- Invalid slot: valid_d=0, reg_write_d=1, mem_write_d=1, rd2_d=32'hDEAD_BEEF → valid_e=0, reg_write_e=0, mem_write_e=0, rd2_e=32'hDEADBEEF.
- ID_EX_STATS_EN: 2 bubbles, 3 flushes, and 1 cycle with flush and bubble both high → bubble_count_e=2, flush_count_e=4. Reset → both 0.

Source files
------------

// File: rtl/id_ex_pipeline_reg.sv
// ---------------------------------------------------------------------------
// id_ex_pipeline_reg
//
// Decode-to-execute pipeline register. Every output is a flop, so execute
// sees the decode control word, operands, immediate, PC values and register
// indices exactly one cycle after decode produced them.
//
// Per-edge priority: flush_e > bubble_e > stall_e > load.
// Flush and bubble both load an all-zero NOP. Stall holds every output,
// including valid_e.
//
// Optional feature (macro ID_EX_STATS_EN): adds the free-running
// bubble_count_e / flush_count_e event counters.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   stall_e           hold current contents
//   flush_e           squash: load a NOP on the next edge
//   bubble_e          insert a NOP (load-use hazard)
//   valid_d           decode slot holds a real instruction
//   *_d               decode-stage control word, operands, PCs, indices
//   valid_e, *_e      registered copies presented to execute
//   bubble_count_e    (ID_EX_STATS_EN only) edges with bubble_e && !flush_e
//   flush_count_e     (ID_EX_STATS_EN only) edges with flush_e
// ---------------------------------------------------------------------------
module id_ex_pipeline_reg #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      stall_e,
    input  logic                      flush_e,
    input  logic                      bubble_e,
    input  logic                      valid_d,
    input  logic [4:0]                alu_src_d,
    input  logic [2:0]                branch_src_d,
    input  logic                      mem_write_d,
    input  logic [1:0]                alu_mux_src_d,
    input  logic [1:0]                wb_src_d,
    input  logic                      reg_write_d,
    input  logic [2:0]                funct3_d,
    input  logic [DATA_WIDTH-1:0]     rd1_d,
    input  logic [DATA_WIDTH-1:0]     rd2_d,
    input  logic [DATA_WIDTH-1:0]     imm_ext_d,
    input  logic [DATA_WIDTH-1:0]     pc_d,
    input  logic [DATA_WIDTH-1:0]     pc_plus4_d,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_d,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_d,
    input  logic [REG_ADDR_WIDTH-1:0] rd_d,
    output logic                      valid_e,
    output logic [4:0]                alu_src_e,
    output logic [2:0]                branch_src_e,
    output logic                      mem_write_e,
    output logic [1:0]                alu_mux_src_e,
    output logic [1:0]                wb_src_e,
    output logic                      reg_write_e,
    output logic [2:0]                funct3_e,
    output logic [DATA_WIDTH-1:0]     rd1_e,
    output logic [DATA_WIDTH-1:0]     rd2_e,
    output logic [DATA_WIDTH-1:0]     imm_ext_e,
    output logic [DATA_WIDTH-1:0]     pc_e,
    output logic [DATA_WIDTH-1:0]     pc_plus4_e,
    output logic [REG_ADDR_WIDTH-1:0] rs1_e,
    output logic [REG_ADDR_WIDTH-1:0] rs2_e,
    output logic [REG_ADDR_WIDTH-1:0] rd_e
`ifdef ID_EX_STATS_EN
    ,
    output logic [31:0]               bubble_count_e,
    output logic [31:0]               flush_count_e
`endif
);

    // Flush and bubble produce the same NOP, so they share one path.
    logic squash;
    assign squash = flush_e | bubble_e;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || squash) begin
            valid_e       <= 1'b0;
            alu_src_e     <= '0;
            branch_src_e  <= '0;
            mem_write_e   <= 1'b0;
            alu_mux_src_e <= '0;
            wb_src_e      <= '0;
            reg_write_e   <= 1'b0;
            funct3_e      <= '0;
            rd1_e         <= '0;
            rd2_e         <= '0;
            imm_ext_e     <= '0;
            pc_e          <= '0;
            pc_plus4_e    <= '0;
            rs1_e         <= '0;
            rs2_e         <= '0;
            rd_e          <= '0;
        end else if (!stall_e) begin
            valid_e       <= valid_d;
            alu_src_e     <= alu_src_d;
            // State-changing controls are gated by valid so that an
            // invalid slot can never write registers, memory or redirect.
            branch_src_e  <= valid_d ? branch_src_d : 3'd0;
            mem_write_e   <= mem_write_d & valid_d;
            reg_write_e   <= reg_write_d & valid_d;
            alu_mux_src_e <= alu_mux_src_d;
            wb_src_e      <= wb_src_d;
            funct3_e      <= funct3_d;
            rd1_e         <= rd1_d;
            rd2_e         <= rd2_d;
            imm_ext_e     <= imm_ext_d;
            pc_e          <= pc_d;
            pc_plus4_e    <= pc_plus4_d;
            rs1_e         <= rs1_d;
            rs2_e         <= rs2_d;
            rd_e          <= rd_d;
        end
    end

`ifdef ID_EX_STATS_EN
    // A cycle with both flush and bubble counts only as a flush, matching
    // the priority of the register itself. Counters wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_count_e <= '0;
            flush_count_e  <= '0;
        end else begin
            if (flush_e) begin
                flush_count_e <= flush_count_e + 32'd1;
            end else if (bubble_e) begin
                bubble_count_e <= bubble_count_e + 32'd1;
            end
        end
    end
`endif

endmodule
